// File: rtl/hdmi_period_scheduler.sv
// Raster timing and TMDS period sequencer for one HDMI/DVI link.
// Places the video preamble and guard band ahead of every active line and registers all encoder controls.
module hdmi_period_scheduler #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int DVI_MODE = 0
) (
  input  logic        pixclk,
  input  logic        reset,
  input  logic        enable,
  output logic [1:0]  period,
  output logic        hsync,
  output logic        vsync,
  output logic [3:0]  ctl,
  output logic [11:0] x,
  output logic [11:0] y,
  output logic        line_start,
  output logic        frame_start,
  output logic        running
);

  typedef enum logic [1:0] {
    PERIOD_CTRL     = 2'd0,
    PERIOD_PREAMBLE = 2'd1,
    PERIOD_GUARD    = 2'd2,
    PERIOD_VIDEO    = 2'd3
  } period_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam int H_TOTAL_I = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL_I = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [11:0] H_ACT       = 12'(H_ACTIVE);
  localparam logic [11:0] H_LAST      = 12'(H_TOTAL_I - 1);
  localparam logic [11:0] HS_START    = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] HS_END      = 12'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [11:0] PRE_START   = 12'(H_TOTAL_I - 10);
  localparam logic [11:0] PRE_END     = 12'(H_TOTAL_I - 3);
  localparam logic [11:0] GUARD_START = 12'(H_TOTAL_I - 2);

  localparam logic [11:0] V_ACT       = 12'(V_ACTIVE);
  localparam logic [11:0] V_ACT_M1    = 12'(V_ACTIVE - 1);
  localparam logic [11:0] V_LAST      = 12'(V_TOTAL_I - 1);
  localparam logic [11:0] VS_START    = 12'(V_ACTIVE + V_FP);
  localparam logic [11:0] VS_END      = 12'(V_ACTIVE + V_FP + V_SYNC);

  localparam bit USE_ISLANDS = (DVI_MODE == 0);

  state_e      state_q, state_d;
  logic [11:0] x_q, x_d;
  logic [11:0] y_q, y_d;
  period_e     period_q, period_d;
  logic        hsync_q, hsync_d;
  logic        vsync_q, vsync_d;
  logic [3:0]  ctl_q, ctl_d;
  logic        line_start_q, line_start_d;
  logic        frame_start_q, frame_start_d;

  logic        at_line_end;
  logic        at_frame_end;

  // Enable only matters in IDLE and at the last pixel of a frame, so a stop always completes the frame.
  always_comb begin
    state_d      = state_q;
    x_d          = x_q;
    y_d          = y_q;
    at_line_end  = (x_q == H_LAST);
    at_frame_end = at_line_end && (y_q == V_LAST);

    case (state_q)
      ST_IDLE: begin
        if (enable) begin
          state_d = ST_RUN;
          x_d     = H_ACT;
          y_d     = V_LAST;
        end
      end
      ST_RUN: begin
        if (at_line_end) begin
          x_d = 12'd0;
          if (at_frame_end) begin
            y_d = 12'd0;
            if (!enable) begin
              state_d = ST_IDLE;
            end
          end else begin
            y_d = y_q + 12'd1;
          end
        end else begin
          x_d = x_q + 12'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        x_d     = 12'd0;
        y_d     = 12'd0;
      end
    endcase
  end

  logic next_line_active;
  logic in_video;
  logic in_guard;
  logic in_preamble;

  // Decode from the next position so every registered output lines up with the registered x/y.
  always_comb begin
    period_d         = PERIOD_CTRL;
    ctl_d            = 4'b0000;
    hsync_d          = 1'b0;
    vsync_d          = 1'b0;
    line_start_d     = 1'b0;
    frame_start_d    = 1'b0;
    next_line_active = (y_d == V_LAST) || (y_d < V_ACT_M1);
    in_video         = (x_d < H_ACT) && (y_d < V_ACT);
    in_guard         = USE_ISLANDS && next_line_active && (x_d >= GUARD_START);
    in_preamble      = USE_ISLANDS && next_line_active &&
                       (x_d >= PRE_START) && (x_d <= PRE_END);

    if (state_d == ST_RUN) begin
      if (in_video) begin
        period_d = PERIOD_VIDEO;
      end else if (in_guard) begin
        period_d = PERIOD_GUARD;
      end else if (in_preamble) begin
        period_d = PERIOD_PREAMBLE;
        ctl_d    = 4'b0001;
      end
      hsync_d       = (x_d >= HS_START) && (x_d < HS_END);
      vsync_d       = (y_d >= VS_START) && (y_d < VS_END);
      line_start_d  = (x_d == 12'd0);
      frame_start_d = (x_d == 12'd0) && (y_d == 12'd0);
    end
  end

  always_ff @(posedge pixclk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      x_q           <= 12'd0;
      y_q           <= 12'd0;
      period_q      <= PERIOD_CTRL;
      hsync_q       <= 1'b0;
      vsync_q       <= 1'b0;
      ctl_q         <= 4'b0000;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      x_q           <= x_d;
      y_q           <= y_d;
      period_q      <= period_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      ctl_q         <= ctl_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign period      = period_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign ctl         = ctl_q;
  assign x           = x_q;
  assign y           = y_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;
  assign running     = (state_q == ST_RUN);

endmodule

// File: tb/tb_hdmi_period_scheduler.sv
// Directed bench for hdmi_period_scheduler: default 640x480 timing plus a reduced raster
// (40x15 total, with DVI_MODE 0 and 1) so that whole frames fit in a short run.
module tb_hdmi_period_scheduler;

   logic pixclk = 1'b0;
   logic reset;
   logic en_def;
   logic en_sm;

   logic [1:0]  d_period, s_period, v_period;
   logic        d_hsync, s_hsync, v_hsync;
   logic        d_vsync, s_vsync, v_vsync;
   logic [3:0]  d_ctl, s_ctl, v_ctl;
   logic [11:0] d_x, s_x, v_x;
   logic [11:0] d_y, s_y, v_y;
   logic        d_ls, s_ls, v_ls;
   logic        d_fs, s_fs, v_fs;
   logic        d_run, s_run, v_run;

   int n_cmp = 0;
   int n_fail = 0;

   always #5 pixclk = ~pixclk;

   hdmi_period_scheduler dut_def (
      .pixclk(pixclk), .reset(reset), .enable(en_def),
      .period(d_period), .hsync(d_hsync), .vsync(d_vsync), .ctl(d_ctl),
      .x(d_x), .y(d_y), .line_start(d_ls), .frame_start(d_fs), .running(d_run)
   );

   hdmi_period_scheduler #(
      .H_ACTIVE(16), .H_FP(4), .H_SYNC(6), .H_BP(14),
      .V_ACTIVE(8), .V_FP(2), .V_SYNC(2), .V_BP(3), .DVI_MODE(0)
   ) dut_sm (
      .pixclk(pixclk), .reset(reset), .enable(en_sm),
      .period(s_period), .hsync(s_hsync), .vsync(s_vsync), .ctl(s_ctl),
      .x(s_x), .y(s_y), .line_start(s_ls), .frame_start(s_fs), .running(s_run)
   );

   hdmi_period_scheduler #(
      .H_ACTIVE(16), .H_FP(4), .H_SYNC(6), .H_BP(14),
      .V_ACTIVE(8), .V_FP(2), .V_SYNC(2), .V_BP(3), .DVI_MODE(1)
   ) dut_dvi (
      .pixclk(pixclk), .reset(reset), .enable(en_sm),
      .period(v_period), .hsync(v_hsync), .vsync(v_vsync), .ctl(v_ctl),
      .x(v_x), .y(v_y), .line_start(v_ls), .frame_start(v_fs), .running(v_run)
   );

   // Advance one clock and land on the falling edge, where outputs are sampled.
   task automatic step();
      @(posedge pixclk);
      @(negedge pixclk);
   endtask

   // Bounded search for a position on the default-timing instance.
   task automatic wait_def(input int tx, input int ty, input int budget, output bit ok);
      int n = 0;
      ok = 1'b0;
      while (n < budget) begin
         if (d_x == 12'(tx) && d_y == 12'(ty)) begin
            ok = 1'b1;
            break;
         end
         step();
         n++;
      end
   endtask

   // Bounded search for a position on the reduced-timing instance.
   task automatic wait_sm(input int tx, input int ty, input int budget, output bit ok);
      int n = 0;
      ok = 1'b0;
      while (n < budget) begin
         if (s_x == 12'(tx) && s_y == 12'(ty)) begin
            ok = 1'b1;
            break;
         end
         step();
         n++;
      end
   endtask

   // Reset values on every instance, and IDLE holds with enable low after release.
   task automatic test_reset();
      reset = 1'b1;
      en_def = 1'b0;
      en_sm = 1'b0;
      @(negedge pixclk);
      @(negedge pixclk);
      n_cmp++;
      if ({d_x, d_y} !== 24'd0) begin
         n_fail++;
         $display("[TB] FAIL reset_xy_def: got x=%0d y=%0d expected 0 0", d_x, d_y);
      end
      n_cmp++;
      if ({d_period, d_hsync, d_vsync, d_ctl, d_ls, d_fs, d_run} !== 11'd0) begin
         n_fail++;
         $display("[TB] FAIL reset_flags_def: got %b expected all zero",
                  {d_period, d_hsync, d_vsync, d_ctl, d_ls, d_fs, d_run});
      end
      n_cmp++;
      if ({s_x, s_y, s_period, s_ctl, s_run, v_x, v_y, v_period, v_ctl, v_run} !== 62'd0) begin
         n_fail++;
         $display("[TB] FAIL reset_small: got sx=%0d sy=%0d sp=%0d vx=%0d vy=%0d vp=%0d expected zeros",
                  s_x, s_y, s_period, v_x, v_y, v_period);
      end
      reset = 1'b0;
      for (int i = 0; i < 4; i++) step();
      n_cmp++;
      if ({d_run, s_run, v_run, d_x, d_y, d_period} !== 29'd0) begin
         n_fail++;
         $display("[TB] FAIL idle_hold: got run=%b%b%b x=%0d y=%0d p=%0d expected idle at 0,0",
                  d_run, s_run, v_run, d_x, d_y, d_period);
      end
   endtask

   // Start from IDLE: tail of line 524 with preamble and guard, then line 0 video.
   task automatic test_startup();
      logic [1:0] exp_p;
      logic [3:0] exp_ctl;
      logic       exp_hs;
      int         vcnt;
      en_def = 1'b1;
      step();
      n_cmp++;
      if ({d_x, d_y, d_run} !== {12'd640, 12'd524, 1'b1}) begin
         n_fail++;
         $display("[TB] FAIL start_pos: got x=%0d y=%0d run=%b expected 640 524 1", d_x, d_y, d_run);
      end
      for (int xx = 640; xx < 800; xx++) begin
         exp_p = (xx >= 798) ? 2'd2 : ((xx >= 790 && xx <= 797) ? 2'd1 : 2'd0);
         exp_ctl = (exp_p == 2'd1) ? 4'b0001 : 4'b0000;
         exp_hs = (xx >= 656 && xx <= 751);
         n_cmp++;
         if ({d_x, d_y, d_period, d_ctl, d_hsync, d_vsync, d_ls, d_fs} !==
             {12'(xx), 12'd524, exp_p, exp_ctl, exp_hs, 1'b0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("[TB] FAIL start_tail x=%0d: got y=%0d p=%0d ctl=%b hs=%b vs=%b ls=%b fs=%b expected p=%0d ctl=%b hs=%b",
                     xx, d_y, d_period, d_ctl, d_hsync, d_vsync, d_ls, d_fs, exp_p, exp_ctl, exp_hs);
         end
         step();
      end
      n_cmp++;
      if ({d_x, d_y, d_fs, d_ls, d_period, d_vsync} !== {24'd0, 1'b1, 1'b1, 2'd3, 1'b0}) begin
         n_fail++;
         $display("[TB] FAIL frame_start: got x=%0d y=%0d fs=%b ls=%b p=%0d vs=%b expected 0 0 1 1 3 0",
                  d_x, d_y, d_fs, d_ls, d_period, d_vsync);
      end
      vcnt = 0;
      for (int i = 0; i < 640; i++) begin
         if (d_period == 2'd3 && d_y == 12'd0) vcnt++;
         step();
      end
      n_cmp++;
      if (vcnt != 640) begin
         n_fail++;
         $display("[TB] FAIL line0_video: got %0d video cycles expected 640", vcnt);
      end
      n_cmp++;
      if ({d_x, d_period} !== {12'd640, 2'd0}) begin
         n_fail++;
         $display("[TB] FAIL line0_end: got x=%0d p=%0d expected 640 0", d_x, d_period);
      end
   endtask

   // Statistics over one complete default line (y=10).
   task automatic test_line();
      bit ok;
      int hs_cnt = 0, hs_first = -1, hs_last = -1, ls_cnt = 0;
      int vid = 0, pre = 0, grd = 0, pre_first = -1, grd_first = -1, ctl_cnt = 0;
      wait_def(0, 10, 20000, ok);
      n_cmp++;
      if (!ok) begin
         n_fail++;
         $display("[TB] FAIL line_wait: got timeout expected position 0,10");
      end
      for (int xx = 0; xx < 800; xx++) begin
         if (d_hsync) begin
            hs_cnt++;
            if (hs_first < 0) hs_first = int'(d_x);
            hs_last = int'(d_x);
         end
         if (d_ls) ls_cnt++;
         if (d_period == 2'd3) vid++;
         if (d_period == 2'd1) begin
            pre++;
            if (pre_first < 0) pre_first = int'(d_x);
         end
         if (d_period == 2'd2) begin
            grd++;
            if (grd_first < 0) grd_first = int'(d_x);
         end
         if (d_ctl == 4'b0001) ctl_cnt++;
         step();
      end
      n_cmp++;
      if (hs_cnt != 96 || hs_first != 656 || hs_last != 751) begin
         n_fail++;
         $display("[TB] FAIL line_hsync: got %0d cycles x=%0d..%0d expected 96 cycles x=656..751",
                  hs_cnt, hs_first, hs_last);
      end
      n_cmp++;
      if (ls_cnt != 1) begin
         n_fail++;
         $display("[TB] FAIL line_start_cnt: got %0d expected 1", ls_cnt);
      end
      n_cmp++;
      if (vid != 640) begin
         n_fail++;
         $display("[TB] FAIL line_video_cnt: got %0d expected 640", vid);
      end
      n_cmp++;
      if (pre != 8 || pre_first != 790 || ctl_cnt != 8) begin
         n_fail++;
         $display("[TB] FAIL line_preamble: got %0d from x=%0d ctl=%0d expected 8 from x=790 ctl=8",
                  pre, pre_first, ctl_cnt);
      end
      n_cmp++;
      if (grd != 2 || grd_first != 798) begin
         n_fail++;
         $display("[TB] FAIL line_guard: got %0d from x=%0d expected 2 from x=798", grd, grd_first);
      end
   endtask

   // Asynchronous reset in the middle of an active line.
   task automatic test_reset_midline();
      bit ok;
      wait_def(300, 20, 20000, ok);
      n_cmp++;
      if (!ok || d_period !== 2'd3) begin
         n_fail++;
         $display("[TB] FAIL midline_pos: got ok=%b p=%0d expected at 300,20 in VIDEO", ok, d_period);
      end
      #2 reset = 1'b1;
      #1;
      n_cmp++;
      if ({d_x, d_y, d_period, d_hsync, d_vsync, d_ctl, d_ls, d_fs, d_run} !== 35'd0) begin
         n_fail++;
         $display("[TB] FAIL async_reset: got x=%0d y=%0d p=%0d run=%b expected all zero before edge",
                  d_x, d_y, d_period, d_run);
      end
      en_def = 1'b0;
      @(negedge pixclk);
      reset = 1'b0;
      for (int i = 0; i < 3; i++) step();
      n_cmp++;
      if ({d_run, d_x, d_y, d_period} !== 27'd0) begin
         n_fail++;
         $display("[TB] FAIL post_reset_idle: got run=%b x=%0d y=%0d p=%0d expected 0 0 0 0",
                  d_run, d_x, d_y, d_period);
      end
   endtask

   // One whole reduced-raster frame on both the HDMI and DVI instances.
   task automatic test_full_frame();
      bit         ok;
      int         ex, ey;
      bit         nla, vid, grd, pre;
      logic [1:0] exp_p, exp_pv;
      logic [14:0] pre_lines = '0;
      logic [14:0] vs_lines = '0;
      int         dvi_vid = 0, dvi_other = 0;
      en_sm = 1'b1;
      step();
      n_cmp++;
      if ({s_x, s_y, s_run, v_x, v_y, v_run} !== {12'd16, 12'd14, 1'b1, 12'd16, 12'd14, 1'b1}) begin
         n_fail++;
         $display("[TB] FAIL small_start: got x=%0d y=%0d run=%b dvi x=%0d y=%0d expected 16 14 1",
                  s_x, s_y, s_run, v_x, v_y);
      end
      wait_sm(0, 0, 200, ok);
      n_cmp++;
      if (!ok) begin
         n_fail++;
         $display("[TB] FAIL small_wait: got timeout expected position 0,0");
      end
      for (int c = 0; c < 600; c++) begin
         ex = c % 40;
         ey = c / 40;
         vid = (ex < 16) && (ey < 8);
         nla = (ey == 14) || (ey < 7);
         grd = nla && (ex >= 38);
         pre = nla && (ex >= 30) && (ex <= 37);
         exp_p = vid ? 2'd3 : (grd ? 2'd2 : (pre ? 2'd1 : 2'd0));
         exp_pv = vid ? 2'd3 : 2'd0;
         n_cmp++;
         if ({s_x, s_y, s_period, s_ctl, s_hsync, s_vsync, s_ls, s_fs} !==
             {12'(ex), 12'(ey), exp_p, (exp_p == 2'd1) ? 4'b0001 : 4'b0000,
              1'((ex >= 20) && (ex < 26)), 1'((ey >= 10) && (ey < 12)),
              1'(ex == 0), 1'(ex == 0 && ey == 0)}) begin
            n_fail++;
            $display("[TB] FAIL hdmi_frame (%0d,%0d): got x=%0d y=%0d p=%0d ctl=%b hs=%b vs=%b expected p=%0d",
                     ex, ey, s_x, s_y, s_period, s_ctl, s_hsync, s_vsync, exp_p);
         end
         n_cmp++;
         if ({v_x, v_y, v_period, v_ctl} !== {12'(ex), 12'(ey), exp_pv, 4'b0000}) begin
            n_fail++;
            $display("[TB] FAIL dvi_frame (%0d,%0d): got x=%0d y=%0d p=%0d ctl=%b expected p=%0d ctl=0000",
                     ex, ey, v_x, v_y, v_period, v_ctl, exp_pv);
         end
         if (s_period == 2'd1 && s_y < 12'd15) pre_lines[s_y[3:0]] = 1'b1;
         if (s_vsync && s_y < 12'd15) vs_lines[s_y[3:0]] = 1'b1;
         if (v_period == 2'd3) dvi_vid++;
         if (v_period == 2'd1 || v_period == 2'd2 || v_ctl != 4'b0000) dvi_other++;
         step();
      end
      n_cmp++;
      if ({s_fs, s_x, s_y} !== {1'b1, 24'd0}) begin
         n_fail++;
         $display("[TB] FAIL frame_length: got fs=%b x=%0d y=%0d after 600 cycles expected 1 0 0",
                  s_fs, s_x, s_y);
      end
      n_cmp++;
      if (pre_lines !== 15'h407F) begin
         n_fail++;
         $display("[TB] FAIL preamble_lines: got %b expected %b", pre_lines, 15'h407F);
      end
      n_cmp++;
      if (vs_lines !== 15'h0C00) begin
         n_fail++;
         $display("[TB] FAIL vsync_lines: got %b expected %b", vs_lines, 15'h0C00);
      end
      n_cmp++;
      if (dvi_vid != 128 || dvi_other != 0) begin
         n_fail++;
         $display("[TB] FAIL dvi_summary: got video=%0d island=%0d expected 128 0", dvi_vid, dvi_other);
      end
   endtask

   // Dropping enable mid-frame finishes the frame, then parks at 0,0; re-enable restarts cleanly.
   task automatic test_drop_enable();
      bit ok;
      int n = 0;
      int dropped_run = 0;
      wait_sm(10, 4, 700, ok);
      n_cmp++;
      if (!ok) begin
         n_fail++;
         $display("[TB] FAIL drop_wait: got timeout expected position 10,4");
      end
      en_sm = 1'b0;
      while (!(s_x == 12'd39 && s_y == 12'd14) && n < 700) begin
         if (!s_run) dropped_run++;
         step();
         n++;
      end
      n_cmp++;
      if (n != 429 || dropped_run != 0 || s_run !== 1'b1) begin
         n_fail++;
         $display("[TB] FAIL drop_complete: got %0d cycles idle_early=%0d run=%b expected 429 0 1",
                  n, dropped_run, s_run);
      end
      step();
      n_cmp++;
      if ({s_run, s_x, s_y, s_period, s_hsync, s_vsync, v_run} !== 30'd0) begin
         n_fail++;
         $display("[TB] FAIL drop_idle: got run=%b x=%0d y=%0d p=%0d dvi_run=%b expected idle at 0,0",
                  s_run, s_x, s_y, s_period, v_run);
      end
      step();
      step();
      n_cmp++;
      if ({s_run, s_x, s_y} !== 25'd0) begin
         n_fail++;
         $display("[TB] FAIL idle_stays: got run=%b x=%0d y=%0d expected 0 0 0", s_run, s_x, s_y);
      end
      en_sm = 1'b1;
      step();
      n_cmp++;
      if ({s_run, s_x, s_y, s_period} !== {1'b1, 12'd16, 12'd14, 2'd0}) begin
         n_fail++;
         $display("[TB] FAIL restart: got run=%b x=%0d y=%0d p=%0d expected 1 16 14 0",
                  s_run, s_x, s_y, s_period);
      end
   endtask

   initial begin
      test_reset();
      test_startup();
      test_line();
      test_reset_midline();
      test_full_frame();
      test_drop_enable();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
